led_write_sched: RTL and testbench

LED_WRITE_SCHED -- requirements
Module: led_write_sched

---
 rtl/led_write_sched.sv | 219 +++++++++++++++++++++
 tb/tb_led_write_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_write_sched.sv
// led_write_sched: schedules control and dot writes to an external LED writer.
// After reset it programs INIT_CW0 then INIT_CW1. From IDLE it then serves
// pending control requests first, then pending display loads, then scroll ticks.
// Each write state pulses its strobe in its first cycle and waits for write_end.
// Optional feature: define LED_SCHED_WATCHDOG_EN to abort a write that gets no
// write_end within 255 cycles of its strobe. An aborted write sets the sticky
// err flag. Without the macro, err is tied to 0.
module led_write_sched #(
  parameter int unsigned SCROLL_DIV = 1000000,
  parameter logic [7:0]  INIT_CW0   = 8'h4F,
  parameter logic [7:0]  INIT_CW1   = 8'h80
) (
  input  logic        led_clk,
  input  logic        rstn,
  input  logic        ctrl_req,
  input  logic [7:0]  ctrl_word,
  input  logic        disp_req,
  input  logic [31:0] disp_chars,
  input  logic        scroll_en,
  input  logic        write_end,
  output logic        control_write,
  output logic        dot_write,
  output logic [7:0]  control_word,
  output logic [7:0]  char0,
  output logic [7:0]  char1,
  output logic [7:0]  char2,
  output logic [7:0]  char3,
  output logic        scrolling_enable,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {StInitW0, StInitW1, StIdle, StCtrlWr, StDotWr} state_e;

  localparam logic [23:0] DivLast = 24'(SCROLL_DIV - 1);

  state_e      state_q;
  logic        issued_q;     // strobe of the current write state already sent
  logic        scroll_wr_q;  // current dot write was triggered by a scroll tick
  logic        ctrl_pend_q;
  logic        dot_pend_q;
  logic        scroll_tick_q;
  logic [7:0]  ctrl_word_q;
  logic [7:0]  buf_q [4];
  logic [1:0]  ptr_q;
  logic [23:0] div_q;

  logic       in_wr, wr_done, wd_expired, step;
  logic       sel_ctrl, sel_dot, sel_tick;
  logic       start_ctrl, start_dot;
  logic [7:0] ld_char [4];

  // Write completion, IDLE arbitration and strobe decode
  always_comb begin
    in_wr      = (state_q != StIdle);
    wr_done    = in_wr && issued_q && write_end;
    step       = wr_done || wd_expired;
    sel_ctrl   = (state_q == StIdle) && ctrl_pend_q;
    sel_dot    = (state_q == StIdle) && !ctrl_pend_q && dot_pend_q;
    sel_tick   = (state_q == StIdle) && !ctrl_pend_q && !dot_pend_q && scroll_tick_q && scroll_en;
    start_ctrl = ((state_q inside {StInitW0, StInitW1, StCtrlWr}) && !issued_q) ||
                 ((state_q == StInitW0) && issued_q && step) || sel_ctrl;
    start_dot  = ((state_q == StDotWr) && !issued_q) || sel_dot || sel_tick;
  end

  // Characters to present: rotated from ptr in scroll mode, straight in static mode
  always_comb begin
    ld_char[0] = scroll_en ? buf_q[ptr_q]         : buf_q[0];
    ld_char[1] = scroll_en ? buf_q[ptr_q + 2'd1]  : buf_q[1];
    ld_char[2] = scroll_en ? buf_q[ptr_q + 2'd2]  : buf_q[2];
    ld_char[3] = scroll_en ? buf_q[ptr_q + 2'd3]  : buf_q[3];
  end

  assign busy = (state_q != StIdle);

  // Main FSM with registered strobes and write data
  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= StInitW0;
      issued_q         <= 1'b0;
      scroll_wr_q      <= 1'b0;
      control_write    <= 1'b0;
      dot_write        <= 1'b0;
      control_word     <= INIT_CW0;
      char0            <= 8'h00;
      char1            <= 8'h00;
      char2            <= 8'h00;
      char3            <= 8'h00;
      scrolling_enable <= 1'b0;
    end else begin
      control_write <= start_ctrl;
      dot_write     <= start_dot;
      unique case (state_q)
        StInitW0: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (step) begin
            // next init strobe goes out on the same edge
            state_q      <= StInitW1;
            control_word <= INIT_CW1;
          end
        end
        StInitW1, StCtrlWr, StDotWr: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (step) begin
            state_q  <= StIdle;
            issued_q <= 1'b0;
          end
        end
        StIdle: begin
          scrolling_enable <= scroll_en;
          if (sel_ctrl) begin
            state_q      <= StCtrlWr;
            issued_q     <= 1'b1;
            control_word <= ctrl_word_q;
          end else if (sel_dot || sel_tick) begin
            state_q     <= StDotWr;
            issued_q    <= 1'b1;
            scroll_wr_q <= sel_tick;
            char0       <= ld_char[0];
            char1       <= ld_char[1];
            char2       <= ld_char[2];
            char3       <= ld_char[3];
          end
        end
        default: begin
          state_q  <= StInitW0;
          issued_q <= 1'b0;
        end
      endcase
    end
  end

  // Request latching (last wins), char buffer and scroll pointer
  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_pend_q <= 1'b0;
      dot_pend_q  <= 1'b0;
      ctrl_word_q <= 8'h00;
      buf_q[0]    <= 8'h00;
      buf_q[1]    <= 8'h00;
      buf_q[2]    <= 8'h00;
      buf_q[3]    <= 8'h00;
      ptr_q       <= 2'd0;
    end else begin
      // a new request on the selection edge stays pending
      if (ctrl_req) begin
        ctrl_pend_q <= 1'b1;
        ctrl_word_q <= ctrl_word;
      end else if (sel_ctrl) begin
        ctrl_pend_q <= 1'b0;
      end
      if (disp_req) begin
        dot_pend_q <= 1'b1;
        buf_q[0]   <= disp_chars[7:0];
        buf_q[1]   <= disp_chars[15:8];
        buf_q[2]   <= disp_chars[23:16];
        buf_q[3]   <= disp_chars[31:24];
      end else if (sel_dot) begin
        dot_pend_q <= 1'b0;
      end
      if (disp_req) begin
        ptr_q <= 2'd0;
      end else if ((state_q == StDotWr) && scroll_wr_q && wr_done) begin
        ptr_q <= ptr_q + 2'd1;
      end
    end
  end

  // Scroll divider; a held tick survives busy periods and repeats collapse
  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      div_q         <= 24'd0;
      scroll_tick_q <= 1'b0;
    end else if (!scroll_en) begin
      div_q         <= 24'd0;
      scroll_tick_q <= 1'b0;
    end else if (div_q == DivLast) begin
      div_q         <= 24'd0;
      scroll_tick_q <= 1'b1;
    end else begin
      div_q <= div_q + 24'd1;
      if (sel_tick) begin
        scroll_tick_q <= 1'b0;
      end
    end
  end

`ifdef LED_SCHED_WATCHDOG_EN
  logic [7:0] wd_q;
  logic       err_q;

  // 254 counted cycles after the strobe means the 255th edge aborts the write
  assign wd_expired = in_wr && issued_q && !write_end && (wd_q == 8'd254);
  assign err        = err_q;

  // Watchdog counter restarted by every strobe; err is sticky until reset
  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (start_ctrl || start_dot) begin
        wd_q <= 8'd0;
      end else if (in_wr && issued_q) begin
        wd_q <= wd_q + 8'd1;
      end
      if (wd_expired) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_led_write_sched.sv
// Testbench for led_write_sched. It acts as the LED writer and records every
// strobed transaction. It then compares those transactions against a
// transaction-level model of the scheduling rules.
module tb_led_write_sched;

  localparam int unsigned ScrollDiv = 10;

  typedef struct {
    bit          is_dot;
    logic [7:0]  word;
    logic [31:0] chars;
    logic        sc;
    int unsigned cyc;
  } txn_t;

  logic        led_clk = 1'b0;
  logic        rstn;
  logic        ctrl_req;
  logic [7:0]  ctrl_word;
  logic        disp_req;
  logic [31:0] disp_chars;
  logic        scroll_en;
  logic        write_end;
  logic        control_write;
  logic        dot_write;
  logic [7:0]  control_word;
  logic [7:0]  char0, char1, char2, char3;
  logic        scrolling_enable;
  logic        busy;
  logic        err;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  bit          auto_end;
  int unsigned wr_lat;
  bit          end_req;
  txn_t        obs_q [$];
  txn_t        exp_q [$];

  led_write_sched #(
    .SCROLL_DIV (ScrollDiv),
    .INIT_CW0   (8'h4F),
    .INIT_CW1   (8'h80)
  ) dut (
    .led_clk          (led_clk),
    .rstn             (rstn),
    .ctrl_req         (ctrl_req),
    .ctrl_word        (ctrl_word),
    .disp_req         (disp_req),
    .disp_chars       (disp_chars),
    .scroll_en        (scroll_en),
    .write_end        (write_end),
    .control_write    (control_write),
    .dot_write        (dot_write),
    .control_word     (control_word),
    .char0            (char0),
    .char1            (char1),
    .char2            (char2),
    .char3            (char3),
    .scrolling_enable (scrolling_enable),
    .busy             (busy),
    .err              (err)
  );

  always #5 led_clk = ~led_clk;

  always @(posedge led_clk) cyc <= cyc + 1;

  // Writer model: records strobes, answers with write_end, checks data hold
  task automatic writer_loop();
    int   wr_cnt = 0;
    bit   prev_strobe = 1'b0;
    bit   strobe, raise;
    txn_t cur;
    cur.is_dot = 1'b0; cur.word = 8'h00; cur.chars = 32'h0; cur.sc = 1'b0; cur.cyc = 0;
    forever begin
      @(negedge led_clk);
      write_end = 1'b0;
      raise     = 1'b0;
      if (!rstn) begin
        wr_cnt = 0; prev_strobe = 1'b0; end_req = 1'b0;
        continue;
      end
      strobe = control_write | dot_write;
      if (strobe) begin
        n_checks++;
        if ((control_write && dot_write) || prev_strobe) begin
          $display("FAIL strobe_shape: cw=%0b dw=%0b prev=%0b, want one strobe for one cycle",
                   control_write, dot_write, prev_strobe);
        end else begin
          n_pass++;
        end
        cur.is_dot = dot_write;
        cur.word   = control_word;
        cur.chars  = {char3, char2, char1, char0};
        cur.sc     = scrolling_enable;
        cur.cyc    = cyc;
        obs_q.push_back(cur);
        if (auto_end) wr_cnt = int'(wr_lat);
      end else if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) raise = 1'b1;
      end
      if (end_req) begin
        raise   = 1'b1;
        end_req = 1'b0;
      end
      if (raise) begin
        write_end = 1'b1;
        n_checks++;
        if ({busy, control_word, char3, char2, char1, char0, scrolling_enable} !==
            {1'b1, cur.word, cur.chars, cur.sc}) begin
          $display("FAIL hold_data: busy=%0b word=%h chars=%h sc=%0b, want busy=1 word=%h chars=%h sc=%0b",
                   busy, control_word, {char3, char2, char1, char0}, scrolling_enable,
                   cur.word, cur.chars, cur.sc);
        end else begin
          n_pass++;
        end
      end
      prev_strobe = strobe;
    end
  endtask

  task automatic wait_quiet(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge led_clk);
      if (!busy) quiet++; else quiet = 0;
      if (quiet >= 6) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge led_clk);
      if (control_write || dot_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_ctrl(input logic [7:0] w);
    @(negedge led_clk);
    ctrl_req = 1'b1; ctrl_word = w;
    @(negedge led_clk);
    ctrl_req = 1'b0;
  endtask

  task automatic pulse_disp(input logic [31:0] c);
    @(negedge led_clk);
    disp_req = 1'b1; disp_chars = c;
    @(negedge led_clk);
    disp_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ctrl_req = 1'b0; ctrl_word = 8'h00; disp_req = 1'b0; disp_chars = 32'h0;
    scroll_en = 1'b0; auto_end = 1'b1; wr_lat = 20; end_req = 1'b0;
    #23;
    n_checks++;
    if ({control_write, dot_write, busy, err} !== 4'b0010) begin
      $display("FAIL reset_ctl: cw,dw,busy,err=%b, want 0010", {control_write, dot_write, busy, err});
    end else n_pass++;
    n_checks++;
    if (control_word !== 8'h4F) $display("FAIL reset_word: got %h, want 4f", control_word);
    else n_pass++;
    n_checks++;
    if ({char3, char2, char1, char0, scrolling_enable} !== 33'h0) begin
      $display("FAIL reset_chars: got %h sc=%0b, want 0", {char3, char2, char1, char0}, scrolling_enable);
    end else n_pass++;
  endtask

  task automatic test_init(input string tag);
    bit ok;
    obs_q.delete();
    @(negedge led_clk);
    rstn = 1'b1;
    wait_quiet(ok);
    n_checks++;
    if (!ok) $display("FAIL %s_timeout: busy stuck, want idle", tag); else n_pass++;
    n_checks++;
    if (obs_q.size() != 2) begin
      $display("FAIL %s_count: got %0d writes, want 2", tag, obs_q.size());
    end else if (obs_q[0].is_dot || obs_q[1].is_dot || obs_q[0].word !== 8'h4F ||
                 obs_q[1].word !== 8'h80) begin
      $display("FAIL %s_words: got %h,%h dot=%0b%0b, want ctrl 4f,80", tag, obs_q[0].word,
               obs_q[1].word, obs_q[0].is_dot, obs_q[1].is_dot);
    end else n_pass++;
    n_checks++;
    if (obs_q.size() == 2 && obs_q[1].cyc - obs_q[0].cyc != wr_lat + 1) begin
      $display("FAIL %s_spacing: got %0d cycles, want %0d", tag, obs_q[1].cyc - obs_q[0].cyc,
               wr_lat + 1);
    end else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0) $display("FAIL %s_idle: busy=%0b err=%0b, want 0 0", tag, busy, err);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    bit ok;
    logic [31:0] c = $urandom;
    obs_q.delete();
    wr_lat = 5;
    @(negedge led_clk);
    ctrl_req = 1'b1; ctrl_word = 8'h3A; disp_req = 1'b1; disp_chars = c;
    @(negedge led_clk);
    ctrl_req = 1'b0; disp_req = 1'b0;
    wait_quiet(ok);
    n_checks++;
    if (!ok || obs_q.size() != 2) begin
      $display("FAIL same_cycle_count: got %0d writes ok=%0b, want 2", obs_q.size(), ok);
    end else if (obs_q[0].is_dot || obs_q[0].word !== 8'h3A || !obs_q[1].is_dot ||
                 obs_q[1].chars !== c || obs_q[1].sc !== 1'b0) begin
      $display("FAIL same_cycle_order: got ctrl %h then chars %h, want ctrl 3a then chars %h",
               obs_q[0].word, obs_q[1].chars, c);
    end else n_pass++;
  endtask

  task automatic test_overwrite();
    bit ok;
    obs_q.delete();
    auto_end = 1'b0;
    pulse_ctrl(8'($urandom));
    wait_strobe(10, ok);
    n_checks++;
    if (!ok) $display("FAIL overwrite_strobe: no control strobe, want one"); else n_pass++;
    pulse_disp(32'h11111111);
    pulse_disp(32'h22222222);
    wr_lat = 4; auto_end = 1'b1; end_req = 1'b1;
    wait_quiet(ok);
    n_checks++;
    if (!ok || obs_q.size() != 2 || !obs_q[1].is_dot || obs_q[1].chars !== 32'h22222222) begin
      $display("FAIL overwrite_dot: got %0d writes last chars=%h, want 2 writes chars 22222222",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].chars : 32'h0);
    end else n_pass++;
  endtask

  task automatic test_random();
    bit ok, have_c, have_d, bad;
    logic [7:0] lc;
    logic [31:0] ld;
    txn_t t;
    for (int r = 0; r < 16; r++) begin
      obs_q.delete(); exp_q.delete();
      auto_end = 1'b0; have_c = 1'b0; have_d = 1'b0;
      t.is_dot = 1'b0; t.word = 8'($urandom); t.chars = 32'h0; t.sc = 1'b0; t.cyc = 0;
      exp_q.push_back(t);
      pulse_ctrl(t.word);
      wait_strobe(10, ok);
      for (int e = 0; e < int'($urandom_range(0, 4)); e++) begin
        if ($urandom_range(0, 1) == 1) begin
          lc = 8'($urandom); have_c = 1'b1; pulse_ctrl(lc);
        end else begin
          ld = $urandom; have_d = 1'b1; pulse_disp(ld);
        end
        repeat ($urandom_range(0, 2)) @(negedge led_clk);
      end
      if (have_c) begin t.is_dot = 1'b0; t.word = lc; exp_q.push_back(t); end
      if (have_d) begin t.is_dot = 1'b1; t.chars = ld; exp_q.push_back(t); end
      wr_lat = $urandom_range(1, 8); auto_end = 1'b1; end_req = 1'b1;
      wait_quiet(ok);
      n_checks++;
      if (!ok || obs_q.size() != exp_q.size()) begin
        $display("FAIL random_count r%0d: got %0d writes ok=%0b, want %0d", r, obs_q.size(), ok,
                 exp_q.size());
      end else n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (k >= obs_q.size()) begin
          $display("FAIL random_txn r%0d t%0d: missing, want dot=%0b", r, k, exp_q[k].is_dot);
          continue;
        end
        bad = (obs_q[k].is_dot !== exp_q[k].is_dot) ||
              (!exp_q[k].is_dot && obs_q[k].word !== exp_q[k].word) ||
              (exp_q[k].is_dot && (obs_q[k].chars !== exp_q[k].chars || obs_q[k].sc !== 1'b0));
        if (bad) begin
          $display("FAIL random_txn r%0d t%0d: got dot=%0b word=%h chars=%h, want dot=%0b word=%h chars=%h",
                   r, k, obs_q[k].is_dot, obs_q[k].word, obs_q[k].chars, exp_q[k].is_dot,
                   exp_q[k].word, exp_q[k].chars);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_scroll();
    bit ok;
    logic [7:0] exp_buf [4];
    exp_buf[0] = 8'h41; exp_buf[1] = 8'h42; exp_buf[2] = 8'h43; exp_buf[3] = 8'h44;
    wr_lat = 3; auto_end = 1'b1;
    pulse_disp({exp_buf[3], exp_buf[2], exp_buf[1], exp_buf[0]});
    wait_quiet(ok);
    obs_q.delete();
    @(negedge led_clk);
    scroll_en = 1'b1;
    repeat (56) @(negedge led_clk);
    scroll_en = 1'b0;
    wait_quiet(ok);
    n_checks++;
    if (!ok || obs_q.size() != 5) $display("FAIL scroll_count: got %0d writes, want 5", obs_q.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < obs_q.size(); k++) begin
      n_checks++;
      if (!obs_q[k].is_dot || obs_q[k].chars[7:0] !== exp_buf[k % 4] || obs_q[k].sc !== 1'b1 ||
          (k > 0 && obs_q[k].cyc - obs_q[k-1].cyc != ScrollDiv)) begin
        $display("FAIL scroll_step%0d: got dot=%0b char0=%h sc=%0b, want dot char0=%h sc=1 every %0d",
                 k, obs_q[k].is_dot, obs_q[k].chars[7:0], obs_q[k].sc, exp_buf[k % 4], ScrollDiv);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    obs_q.delete();
    auto_end = 1'b0;
    pulse_disp($urandom);
    wait_strobe(10, ok);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (!ok || dot_write !== 1'b0 || busy !== 1'b1 || control_word !== 8'h4F ||
        {char3, char2, char1, char0} !== 32'h0) begin
      $display("FAIL reset_mid: ok=%0b dw=%0b busy=%0b word=%h chars=%h, want dw=0 busy=1 word=4f chars=0",
               ok, dot_write, busy, control_word, {char3, char2, char1, char0});
    end else n_pass++;
    auto_end = 1'b1;
    wr_lat = $urandom_range(1, 10);
    test_init("reinit");
  endtask

`ifdef LED_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok;
    auto_end = 1'b0;
    pulse_ctrl(8'($urandom));
    wait_strobe(10, ok);
    repeat (254) @(negedge led_clk);
    n_checks++;
    if (!ok || busy !== 1'b1) $display("FAIL wd_early: busy=%0b, want 1 at 254", busy); else n_pass++;
    @(negedge led_clk);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1) $display("FAIL wd_abort: busy=%0b err=%0b, want 0 1", busy, err);
    else n_pass++;
    repeat (30) @(negedge led_clk);
    n_checks++;
    if (err !== 1'b1) $display("FAIL wd_sticky: err=%0b, want 1", err); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL wd_clear: err=%0b, want 0", err); else n_pass++;
    auto_end = 1'b1; wr_lat = 20;
    test_init("wd_reinit");
  endtask
`else
  task automatic test_err_tied();
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_tied: err=%0b, want 0", err); else n_pass++;
  endtask
`endif

  initial begin
    write_end = 1'b0;
    fork
      writer_loop();
    join_none
    test_reset();
    test_init("init");
    test_same_cycle();
    test_overwrite();
    test_random();
    test_scroll();
    test_reset_mid();
`ifdef LED_SCHED_WATCHDOG_EN
    test_watchdog();
`else
    test_err_tied();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
